// File: rtl/char_hp_ctrl.sv
// Player health FSM: bounding-box overlap and attack-pulse damage, frame-counted invulnerability, heal, death.
// Every output is registered and changes one clk after its cause; contact damage takes two. No backpressure: events are sampled every cycle.
module char_hp_ctrl #(
  parameter int MAX_HP        = 5,
  parameter int DMG           = 1,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        game_start,
  input  logic [1:0]  game_active,
  input  logic [11:0] char_x,
  input  logic [11:0] char_y,
  input  logic [11:0] char_lng,
  input  logic [11:0] char_hgt,
  input  logic [11:0] boss_x,
  input  logic [11:0] boss_y,
  input  logic [11:0] boss_lng,
  input  logic [11:0] boss_hgt,
  input  logic        boss_attack_hit,
  input  logic        heal_req,
  output logic [3:0]  char_hp,
  output logic        invuln,
  output logic        hit_pulse,
  output logic        char_dead
);

  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

  localparam logic [3:0] MAX_HP_L = 4'(MAX_HP);
  localparam logic [3:0] DMG_L    = 4'(DMG);
  localparam logic [7:0] INV_L    = 8'(INVULN_FRAMES);

  state_t      state_q, state_d;
  logic [3:0]  hp_q, hp_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        overlap_q, overlap_d;
  logic        invuln_q, invuln_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic        char_dead_q, char_dead_d;

  logic        run;
  logic        dmg_evt;
  logic [3:0]  heal_hp;
  logic [3:0]  dmg_hp;

  // Sums are widened to 13 bits so large boxes near the screen edge cannot wrap.
  always_comb begin
    overlap_d = ({1'b0, char_x} < ({1'b0, boss_x} + {1'b0, boss_lng})) &&
                ({1'b0, boss_x} < ({1'b0, char_x} + {1'b0, char_lng})) &&
                ({1'b0, char_y} < ({1'b0, boss_y} + {1'b0, boss_hgt})) &&
                ({1'b0, boss_y} < ({1'b0, char_y} + {1'b0, char_hgt}));
  end

  assign run     = (game_active == 2'b01);
  assign dmg_evt = (frame_tick & overlap_q) | boss_attack_hit;
  assign heal_hp = (hp_q < MAX_HP_L) ? hp_q + 4'd1 : MAX_HP_L;
  assign dmg_hp  = (hp_q > DMG_L) ? hp_q - DMG_L : 4'd0;

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    inv_cnt_d   = inv_cnt_q;
    hit_pulse_d = 1'b0;
    if (game_start) begin
      state_d   = ALIVE;
      hp_d      = MAX_HP_L;
      inv_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          hp_d = MAX_HP_L;
        end
        ALIVE: begin
          if (run) begin
            if (dmg_evt) begin
              hit_pulse_d = 1'b1;
              hp_d        = dmg_hp;
              if (dmg_hp == 4'd0) begin
                state_d = DEAD;
              end else begin
                state_d   = INVULN;
                inv_cnt_d = INV_L;
              end
            end else if (heal_req) begin
              hp_d = heal_hp;
            end
          end
        end
        INVULN: begin
          if (run) begin
            if (heal_req) hp_d = heal_hp;
            if (frame_tick) begin
              if (inv_cnt_q == 8'd1) begin
                state_d   = ALIVE;
                inv_cnt_d = 8'd0;
              end else begin
                inv_cnt_d = inv_cnt_q - 8'd1;
              end
            end
          end
        end
        DEAD: begin
          hp_d = 4'd0;
        end
        default: begin
          state_d = IDLE;
          hp_d    = MAX_HP_L;
        end
      endcase
    end
    invuln_d    = (state_d == INVULN);
    char_dead_d = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hp_q        <= MAX_HP_L;
      inv_cnt_q   <= 8'd0;
      overlap_q   <= 1'b0;
      invuln_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
      char_dead_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      inv_cnt_q   <= inv_cnt_d;
      overlap_q   <= overlap_d;
      invuln_q    <= invuln_d;
      hit_pulse_q <= hit_pulse_d;
      char_dead_q <= char_dead_d;
    end
  end

  assign char_hp   = hp_q;
  assign invuln    = invuln_q;
  assign hit_pulse = hit_pulse_q;
  assign char_dead = char_dead_q;

endmodule

// File: tb/tb_char_hp_ctrl.sv
// Scoreboarded bench for char_hp_ctrl: directed scenarios followed by random traffic, all checked against a behavioural health model.
module tb_char_hp_ctrl;
  localparam int MAX_HP = 5;
  localparam int DMG    = 1;
  localparam int INV    = 60;

  logic        clk = 1'b0;
  logic        rst, frame_tick, game_start, boss_attack_hit, heal_req;
  logic [1:0]  game_active;
  logic [11:0] char_x, char_y, char_lng, char_hgt;
  logic [11:0] boss_x, boss_y, boss_lng, boss_hgt;
  logic [3:0]  char_hp;
  logic        invuln, hit_pulse, char_dead;

  always #5 clk = ~clk;

  char_hp_ctrl #(.MAX_HP(MAX_HP), .DMG(DMG), .INVULN_FRAMES(INV)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_start(game_start),
    .game_active(game_active), .char_x(char_x), .char_y(char_y),
    .char_lng(char_lng), .char_hgt(char_hgt), .boss_x(boss_x), .boss_y(boss_y),
    .boss_lng(boss_lng), .boss_hgt(boss_hgt), .boss_attack_hit(boss_attack_hit),
    .heal_req(heal_req), .char_hp(char_hp), .invuln(invuln),
    .hit_pulse(hit_pulse), .char_dead(char_dead)
  );

  typedef struct {
    int hp;
    bit inv;
    bit hit;
    bit dead;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: a fight is either not started, running, or lost; invulnerability is a frame countdown.
  bit m_started = 0, m_dead = 0, m_ovl = 0, m_hit = 0;
  int m_hp = MAX_HP, m_inv_left = 0;

  function automatic bit boxes_overlap();
    int cx = int'(char_x), cy = int'(char_y), cl = int'(char_lng), ch = int'(char_hgt);
    int bx = int'(boss_x), by = int'(boss_y), bl = int'(boss_lng), bh = int'(boss_hgt);
    return (cx < bx + bl) && (bx < cx + cl) && (cy < by + bh) && (by < cy + ch);
  endfunction

  task automatic model_step();
    bit ovl_now = boxes_overlap();
    bit dmg     = (frame_tick && m_ovl) || boss_attack_hit;
    bit running = (game_active == 2'b01);
    m_hit = 0;
    if (rst) begin
      m_started = 0; m_dead = 0; m_inv_left = 0; m_hp = MAX_HP; ovl_now = 0;
    end else if (game_start) begin
      m_started = 1; m_dead = 0; m_inv_left = 0; m_hp = MAX_HP;
    end else if (m_started && !m_dead && running) begin
      if (m_inv_left == 0) begin
        if (dmg) begin
          m_hit = 1;
          m_hp  = (m_hp - DMG < 0) ? 0 : m_hp - DMG;
          if (m_hp == 0) m_dead = 1;
          else m_inv_left = INV;
        end else if (heal_req) begin
          m_hp = (m_hp + 1 > MAX_HP) ? MAX_HP : m_hp + 1;
        end
      end else begin
        if (heal_req) m_hp = (m_hp + 1 > MAX_HP) ? MAX_HP : m_hp + 1;
        if (frame_tick) m_inv_left = m_inv_left - 1;
      end
    end
    m_ovl = ovl_now;
  endtask

  // Sample the current inputs into the model, queue the response the DUT owes next edge, then advance.
  task automatic cycle();
    exp_t e;
    model_step();
    e.hp = m_hp; e.inv = (m_inv_left > 0); e.hit = m_hit; e.dead = m_dead;
    exp_q.push_back(e);
    @(negedge clk);
    frame_tick = 0; game_start = 0; boss_attack_hit = 0; heal_req = 0;
  endtask

  task automatic run_cycles(input int n, input int tick_every);
    for (int i = 0; i < n; i++) begin
      frame_tick = (i % tick_every == 0);
      cycle();
    end
  endtask

  task automatic set_geo(input int cx, input int cy, input int cl, input int ch,
                         input int bx, input int by, input int bl, input int bh);
    char_x = 12'(cx); char_y = 12'(cy); char_lng = 12'(cl); char_hgt = 12'(ch);
    boss_x = 12'(bx); boss_y = 12'(by); boss_lng = 12'(bl); boss_hgt = 12'(bh);
  endtask

  task automatic start_fight();
    game_start = 1;
    cycle();
  endtask

  task automatic attack_and_recover();
    boss_attack_hit = 1;
    cycle();
    run_cycles(INV + 2, 1);
  endtask

  function automatic void check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endfunction

  // Monitor: the DUT presents a full output word every clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("char_hp", int'(char_hp), e.hp);
        check("invuln", int'(invuln), int'(e.inv));
        check("hit_pulse", int'(hit_pulse), int'(e.hit));
        check("char_dead", int'(char_dead), int'(e.dead));
      end
    end
  end

  initial begin
    rst = 1; frame_tick = 0; game_start = 0; boss_attack_hit = 0; heal_req = 0;
    game_active = 2'b01;
    set_geo(0, 0, 10, 10, 500, 500, 10, 10);
    cycle(); cycle();
    rst = 0;
    run_cycles(4, 1);

    // Sustained contact damage with invulnerability windows.
    start_fight();
    set_geo(100, 100, 50, 50, 120, 120, 40, 40);
    run_cycles(300, 2);

    // Touching edges horizontally, then vertically.
    start_fight();
    set_geo(100, 100, 50, 50, 150, 100, 40, 40);
    run_cycles(40, 2);
    set_geo(100, 100, 50, 50, 100, 150, 40, 40);
    run_cycles(40, 2);
    set_geo(4095, 4095, 4095, 4095, 4000, 4000, 200, 200);
    run_cycles(6, 2);

    // Lethal hit, dead ignores everything, restart.
    set_geo(0, 0, 10, 10, 500, 500, 10, 10);
    start_fight();
    for (int k = 0; k < 4; k++) attack_and_recover();
    boss_attack_hit = 1; cycle();
    boss_attack_hit = 1; cycle();
    heal_req = 1; cycle();
    run_cycles(5, 1);
    start_fight();
    run_cycles(3, 1);

    // Heal and hit together, heal during invulnerability, heal at full.
    attack_and_recover();
    attack_and_recover();
    heal_req = 1; boss_attack_hit = 1; cycle();
    heal_req = 1; cycle();
    run_cycles(INV + 2, 1);
    for (int k = 0; k < 4; k++) begin heal_req = 1; cycle(); end

    // Freeze in the middle of invulnerability.
    start_fight();
    boss_attack_hit = 1; cycle();
    run_cycles(30, 1);
    game_active = 2'b10;
    for (int k = 0; k < 20; k++) begin
      frame_tick = 1; boss_attack_hit = 1; heal_req = 1; cycle();
    end
    game_active = 2'b01;
    run_cycles(35, 1);

    // Reset in the middle of invulnerability, then contact while idle.
    start_fight();
    boss_attack_hit = 1; cycle();
    boss_attack_hit = 1; cycle();
    run_cycles(4, 1);
    rst = 1; cycle();
    rst = 0;
    set_geo(100, 100, 50, 50, 120, 120, 40, 40);
    run_cycles(20, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      game_start      = ($urandom_range(0, 79) == 0);
      frame_tick      = ($urandom_range(0, 2) == 0);
      boss_attack_hit = ($urandom_range(0, 24) == 0);
      heal_req        = ($urandom_range(0, 9) == 0);
      game_active     = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_geo($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
        else
          set_geo($urandom_range(90, 110), $urandom_range(90, 110), $urandom_range(0, 30),
                  $urandom_range(0, 30), $urandom_range(90, 130), $urandom_range(90, 130),
                  $urandom_range(0, 30), $urandom_range(0, 30));
      end
      cycle();
    end
    rst = 0;
    cycle();

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
